// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and pipeline-entry record for the decode hazard controller.
// Class codes, non-writing ALU function codes and the register-file write-enable helper.
package hazard_ctrl_pkg;

   localparam logic [1:0] CLS_ALU = 2'b11;
   localparam logic [1:0] CLS_MEM = 2'b01;
   localparam logic [1:0] CLS_IMM = 2'b00;
   localparam logic [4:0] OP_LDI  = 5'b10000;

   localparam logic [3:0] FN_NW0 = 4'b0101;
   localparam logic [3:0] FN_NW1 = 4'b1101;
   localparam logic [3:0] FN_NW2 = 4'b1110;
   localparam logic [3:0] FN_NW3 = 4'b1111;

   typedef struct packed {
      logic       valid;
      logic       writes;
      logic [2:0] dest;
   } entry_t;

   // ALU function codes that compute flags only and leave the register file alone
   function automatic logic fn_no_write(input logic [3:0] fn);
      logic nw;
      case (fn)
         FN_NW0, FN_NW1, FN_NW2, FN_NW3: nw = 1'b1;
         default:                        nw = 1'b0;
      endcase
      return nw;
   endfunction

endpackage

// File: rtl/instr_regdec.sv
// Combinational register-usage decode: write enable, destination and up to two source fields.
module instr_regdec
   import hazard_ctrl_pkg::*;
(
   input  logic [15:0] instr,
   output logic        writes,
   output logic [2:0]  dest,
   output logic        src_a_en,
   output logic [2:0]  src_a,
   output logic        src_b_en,
   output logic [2:0]  src_b
);

   // Decode by major class; src_b always carries [10:8] so class 00 uses it alone
   always_comb begin
      writes   = 1'b0;
      dest     = instr[10:8];
      src_a_en = 1'b0;
      src_a    = instr[13:11];
      src_b_en = 1'b0;
      src_b    = instr[10:8];
      case (instr[15:14])
         CLS_ALU: begin
            writes   = ~fn_no_write(instr[7:4]);
            src_a_en = 1'b1;
            src_b_en = 1'b1;
         end
         CLS_MEM: begin
            src_a_en = 1'b1;
            src_b_en = 1'b1;
         end
         CLS_IMM: begin
            writes   = 1'b1;
            dest     = instr[13:11];
            src_b_en = 1'b1;
         end
         default: begin
            writes = (instr[15:11] == OP_LDI);
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage RAW interlock: tracks in-flight register writers and stalls decode on conflict.
// The oldest tracked stage drives the register-file write port.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int DEPTH = 3
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] id_instr,
   input  logic        id_valid,
   input  logic        flush,
   output logic        id_ready,
   output logic        ex_valid,
   output logic        wb_rf_enable,
   output logic [2:0]  wb_dest,
   output logic [15:0] stall_count
);

   entry_t      pipe_r [DEPTH];
   entry_t      load_s;
   logic [15:0] stall_count_r;
   logic        dec_writes_s;
   logic [2:0]  dec_dest_s;
   logic        src_a_en_s;
   logic [2:0]  src_a_s;
   logic        src_b_en_s;
   logic [2:0]  src_b_s;
   logic        hazard_s;
   logic        stall_s;

   instr_regdec u_regdec (
      .instr    (id_instr),
      .writes   (dec_writes_s),
      .dest     (dec_dest_s),
      .src_a_en (src_a_en_s),
      .src_a    (src_a_s),
      .src_b_en (src_b_en_s),
      .src_b    (src_b_s)
   );

   // Compare sources against every stage except the last, whose write lands this cycle
   always_comb begin
      hazard_s = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         hazard_s = hazard_s | (pipe_r[i].valid & pipe_r[i].writes &
                    ((src_a_en_s & (pipe_r[i].dest == src_a_s)) |
                     (src_b_en_s & (pipe_r[i].dest == src_b_s))));
      end
      hazard_s = hazard_s & id_valid;
   end

   // Handshake, stage-0 load and writeback strobe; reset forces all of them quiet
   always_comb begin
      id_ready     = 1'b0;
      ex_valid     = 1'b0;
      wb_rf_enable = 1'b0;
      wb_dest      = 3'd0;
      load_s       = '0;
      if (!rst) begin
         id_ready     = id_valid & ~hazard_s;
         ex_valid     = id_ready & ~flush;
         wb_rf_enable = pipe_r[DEPTH-1].valid & pipe_r[DEPTH-1].writes;
         if (wb_rf_enable) begin
            wb_dest = pipe_r[DEPTH-1].dest;
         end else begin
            wb_dest = 3'd0;
         end
         if (ex_valid) begin
            load_s = '{valid: 1'b1, writes: dec_writes_s, dest: dec_dest_s};
         end else begin
            load_s = '0;
         end
      end else begin
         load_s = '0;
      end
   end

   assign stall_s     = id_valid & ~id_ready;
   assign stall_count = stall_count_r;

   // Tracking pipeline advances every cycle; stall counter saturates
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_r[i] <= '0;
         end
         stall_count_r <= 16'd0;
      end else begin
         pipe_r[0] <= load_s;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
         if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
         end else begin
            stall_count_r <= stall_count_r;
         end
      end
   end

endmodule
